// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter with run-time parity and stop-length
// selection, paced by an oversampling tick and fed through valid/ready.
// Optional feature macro: UART_TX_PARITY_EN (builds the PARITY state and
// parity generator; when undefined, parity_mode is ignored and frames
// carry no parity bit).

module uart_tx_frame #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_tick,
  input  logic [DATA_BITS-1:0] tx_data_in,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [1:0]           parity_mode,
  input  logic [1:0]           stop_sel,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx_data
);

  localparam int TW = $clog2(2 * OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] BIT_LAST    = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP15_LAST = TW'(OVERSAMPLE + OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] STOP2_LAST  = TW'(2 * OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST   = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [TW-1:0]        tick_cnt;
  logic [TW-1:0]        stop_last;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 accept;
  logic                 bit_end;
  logic                 stop_end;
  logic                 step;
  logic                 line_next;

`ifdef UART_TX_PARITY_EN
  logic par_en;
  logic par_bit;
`else
  logic unused_parity;
  assign unused_parity = ^parity_mode;
`endif

  assign tx_ready = (state == IDLE);
  assign accept   = tx_valid && tx_ready;
  assign bit_end  = sample_tick && (tick_cnt == BIT_LAST);
  assign stop_end = sample_tick && (tick_cnt == stop_last);
  assign step     = (state == STOP) ? stop_end : bit_end;

  // Next-state decode and the line level the current state wants to drive.
  always_comb begin
    state_next = state;
    line_next  = 1'b1;
    case (state)
      IDLE: begin
        if (accept) state_next = START;
      end
      START: begin
        line_next = 1'b0;
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        line_next = shift_reg[0];
        if (bit_end && (bit_cnt == DATA_LAST)) begin
`ifdef UART_TX_PARITY_EN
          state_next = par_en ? PARITY : STOP;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        line_next = par_bit;
        if (bit_end) state_next = STOP;
      end
`endif
      STOP: begin
        if (stop_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, frame latches, tick/bit counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      stop_last <= '0;
      tx_data   <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en    <= 1'b0;
      par_bit   <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      tx_data <= line_next;
      tx_busy <= (state_next != IDLE);
      tx_done <= (state == STOP) && (state_next == IDLE);
      if (accept) begin
        shift_reg <= tx_data_in;
        tick_cnt  <= '0;
        bit_cnt   <= '0;
        case (stop_sel)
          2'b00:   stop_last <= BIT_LAST;
          2'b01:   stop_last <= STOP15_LAST;
          default: stop_last <= STOP2_LAST;
        endcase
`ifdef UART_TX_PARITY_EN
        par_en  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
        par_bit <= (^tx_data_in) ^ (parity_mode == 2'b10);
`endif
      end else if ((state != IDLE) && sample_tick) begin
        if (step) begin
          tick_cnt <= '0;
          if (state == DATA) begin
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + 1'b1;
          end
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame: a per-clock waveform model expands every
// accepted word into its expected line/busy/done timeline, a compare
// process checks the DUT against it each cycle, and directed frames pin
// hand-computed bit values and frame lengths.

module tb_uart_tx_frame;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int DEPTH      = 8192;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_tick;
  logic [7:0] tx_data_in;
  logic       tx_valid;
  logic       tx_ready;
  logic [1:0] parity_mode;
  logic [1:0] stop_sel;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_data;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int curj     = 0;

  logic exp_line [DEPTH];
  logic exp_busy [DEPTH];
  logic exp_done [DEPTH];

  uart_tx_frame #(
    .DATA_BITS (DATA_BITS),
    .OVERSAMPLE(OVERSAMPLE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_tick(sample_tick),
    .tx_data_in (tx_data_in),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .parity_mode(parity_mode),
    .stop_sel   (stop_sel),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_data    (tx_data)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %b expected %b", name, cyc, actual, expected);
    end
  endtask

  // Idle-line defaults for the whole expected timeline.
  initial begin
    for (int k = 0; k < DEPTH; k++) begin
      exp_line[k] = 1'b1;
      exp_busy[k] = 1'b0;
      exp_done[k] = 1'b0;
    end
  end

  // Waveform model: on every accepted word, write the frame's per-clock line
  // levels, busy window and done pulse into the expected timeline.
  always @(posedge clk) begin : model
    int   n;
    int   stop_len;
    int   ones;
    logic par_val;
    logic q[$];
    n = cyc + 1;
    if (rst) begin
      for (int k = n; k < DEPTH; k++) begin
        exp_line[k] = 1'b1;
        exp_busy[k] = 1'b0;
        exp_done[k] = 1'b0;
      end
    end else if (tx_valid && !exp_busy[cyc]) begin
      q.delete();
      repeat (OVERSAMPLE) q.push_back(1'b0);
      for (int b = 0; b < DATA_BITS; b++)
        repeat (OVERSAMPLE) q.push_back(tx_data_in[b]);
`ifdef UART_TX_PARITY_EN
      ones = $countones(tx_data_in);
      if (parity_mode == 2'b01) begin
        par_val = (ones % 2 == 1);
        repeat (OVERSAMPLE) q.push_back(par_val);
      end else if (parity_mode == 2'b10) begin
        par_val = (ones % 2 == 0);
        repeat (OVERSAMPLE) q.push_back(par_val);
      end
`endif
      if (stop_sel == 2'b00) stop_len = OVERSAMPLE;
      else if (stop_sel == 2'b01) stop_len = (3 * OVERSAMPLE) / 2;
      else stop_len = 2 * OVERSAMPLE;
      repeat (stop_len) q.push_back(1'b1);
      for (int c = 0; c < q.size(); c++) begin
        if (n + c < DEPTH) exp_busy[n + c] = 1'b1;
        if (n + 1 + c < DEPTH) exp_line[n + 1 + c] = q[c];
      end
      if (n + q.size() < DEPTH) exp_done[n + q.size()] = 1'b1;
    end
    cyc = n;
  end

  // Every-cycle comparison of all outputs against the model timeline.
  always @(negedge clk) begin
    if (cyc >= 1 && cyc < DEPTH) begin
      checkOutput("line", tx_data, exp_line[cyc]);
      checkOutput("busy", tx_busy, exp_busy[cyc]);
      checkOutput("done", tx_done, exp_done[cyc]);
      checkOutput("ready", tx_ready, !exp_busy[cyc]);
    end
  end

  // Present one word for a single accept edge; returns at the first
  // falling edge after the accept edge (frame-relative cycle 0).
  task automatic applyStimulus(input logic [7:0] d, input logic [1:0] pm, input logic [1:0] ss);
    @(negedge clk);
    tx_data_in  = d;
    parity_mode = pm;
    stop_sel    = ss;
    tx_valid    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    curj     = 0;
  endtask

  task automatic gotoJ(input int j);
    while (curj < j) begin
      @(negedge clk);
      curj++;
    end
  endtask

  // Directed scenarios with hand-computed line levels and frame lengths.
  initial begin
    logic [9:0] pat;
    rst         = 1'b1;
    sample_tick = 1'b1;
    tx_valid    = 1'b0;
    tx_data_in  = 8'h00;
    parity_mode = 2'b00;
    stop_sel    = 2'b00;
    repeat (3) @(negedge clk);
    checkOutput("rst_line", tx_data, 1'b1);
    checkOutput("rst_busy", tx_busy, 1'b0);
    checkOutput("rst_done", tx_done, 1'b0);
    checkOutput("rst_ready", tx_ready, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // 0x55 8N1: alternating line, 160-clock frame.
    pat = 10'b1010101010;
    applyStimulus(8'h55, 2'b00, 2'b00);
    for (int i = 0; i < 10; i++) begin
      gotoJ(1 + 16 * i + 8);
      checkOutput("t55_bit", tx_data, pat[i]);
      checkOutput("t55_busy", tx_busy, 1'b1);
    end
    gotoJ(159);
    checkOutput("t55_done_early", tx_done, 1'b0);
    gotoJ(160);
    checkOutput("t55_done", tx_done, 1'b1);
    checkOutput("t55_ready", tx_ready, 1'b1);
    gotoJ(161);
    checkOutput("t55_done_pulse", tx_done, 1'b0);

`ifdef UART_TX_PARITY_EN
    // 0x07 even then odd parity: 11-bit frames.
    applyStimulus(8'h07, 2'b01, 2'b00);
    gotoJ(153);
    checkOutput("par_even", tx_data, 1'b1);
    gotoJ(175);
    checkOutput("par_even_len_early", tx_done, 1'b0);
    gotoJ(176);
    checkOutput("par_even_len", tx_done, 1'b1);
    applyStimulus(8'h07, 2'b10, 2'b00);
    gotoJ(153);
    checkOutput("par_odd", tx_data, 1'b0);
    gotoJ(176);
    checkOutput("par_odd_len", tx_done, 1'b1);
`else
    // Parity request ignored: 10-bit frame, stop where parity would be.
    applyStimulus(8'h07, 2'b10, 2'b00);
    gotoJ(153);
    checkOutput("nopar_stop", tx_data, 1'b1);
    gotoJ(160);
    checkOutput("nopar_len", tx_done, 1'b1);
`endif

    // 0xFF with 1.5 and 2 stop bits.
    applyStimulus(8'hFF, 2'b00, 2'b01);
    gotoJ(145);
    checkOutput("stop15_first", tx_data, 1'b1);
    gotoJ(167);
    checkOutput("stop15_early", tx_done, 1'b0);
    gotoJ(168);
    checkOutput("stop15_done", tx_done, 1'b1);
    applyStimulus(8'hFF, 2'b00, 2'b10);
    gotoJ(175);
    checkOutput("stop2_early", tx_done, 1'b0);
    gotoJ(176);
    checkOutput("stop2_done", tx_done, 1'b1);

    // Back-to-back 0xA5 then 0x3C with tx_valid held high.
    @(negedge clk);
    tx_data_in  = 8'hA5;
    parity_mode = 2'b00;
    stop_sel    = 2'b00;
    tx_valid    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    curj       = 0;
    tx_data_in = 8'h3C;
    gotoJ(80);
    checkOutput("b2b_ready_low", tx_ready, 1'b0);
    gotoJ(160);
    checkOutput("b2b_done", tx_done, 1'b1);
    checkOutput("b2b_ready", tx_ready, 1'b1);
    gotoJ(161);
    checkOutput("b2b_gap_line", tx_data, 1'b1);
    checkOutput("b2b_second_busy", tx_busy, 1'b1);
    tx_valid = 1'b0;
    curj     = 0;
    gotoJ(1);
    checkOutput("b2b_second_start", tx_data, 1'b0);
    gotoJ(25);
    checkOutput("b2b_3c_bit0", tx_data, 1'b0);
    gotoJ(57);
    checkOutput("b2b_3c_bit2", tx_data, 1'b1);
    gotoJ(160);
    checkOutput("b2b_second_done", tx_done, 1'b1);

    // Reset during data bit 3 of 0x81, then a clean 0x81 frame.
    applyStimulus(8'h81, 2'b00, 2'b00);
    gotoJ(70);
    rst = 1'b1;
    gotoJ(71);
    checkOutput("abort_line", tx_data, 1'b1);
    checkOutput("abort_busy", tx_busy, 1'b0);
    checkOutput("abort_done", tx_done, 1'b0);
    rst = 1'b0;
    gotoJ(160);
    checkOutput("abort_no_done", tx_done, 1'b0);
    applyStimulus(8'h81, 2'b00, 2'b00);
    gotoJ(25);
    checkOutput("r81_bit0", tx_data, 1'b1);
    gotoJ(73);
    checkOutput("r81_bit3", tx_data, 1'b0);
    gotoJ(137);
    checkOutput("r81_bit7", tx_data, 1'b1);
    gotoJ(160);
    checkOutput("r81_done", tx_done, 1'b1);

    // Mid-frame control changes and a new word while busy.
    applyStimulus(8'hC3, 2'b00, 2'b00);
    gotoJ(20);
    parity_mode = 2'b01;
    stop_sel    = 2'b10;
    tx_data_in  = 8'h00;
    tx_valid    = 1'b1;
    gotoJ(100);
    checkOutput("mid_ready", tx_ready, 1'b0);
    tx_valid = 1'b0;
    gotoJ(121);
    checkOutput("mid_bit6", tx_data, 1'b1);
    gotoJ(160);
    checkOutput("mid_done", tx_done, 1'b1);
    gotoJ(165);
    checkOutput("mid_not_consumed", tx_busy, 1'b0);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter for the Basys3 serial path, replacing the fixed 8N1 transmitter. Serialises one parallel word per frame with run-time selectable parity and stop length, paced by the shared oversampling baud tick. Uses a valid/ready handshake so it can be fed directly from the TX FIFO or a register stage.

## Interface
- `DATA_BITS`, 8: data bits per frame; legal range 5..9.
- `OVERSAMPLE`, 16: `sample_tick` pulses per bit; even, at least 4.

- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `sample_tick` in 1: one-cycle baud-rate pulse at `OVERSAMPLE`× bit rate.
- `tx_data_in` in `DATA_BITS`: word to transmit.
- `tx_valid` in 1: `tx_data_in` is valid.
- `tx_ready` out 1: block accepts a word this cycle.
- `parity_mode` in 2: 00 none, 01 even, 10 odd, 11 none.
- `stop_sel` in 2: 00 one stop bit, 01 1.5, 10 two, 11 two.
- `tx_busy` out 1: a frame is in progress.
- `tx_done` out 1: one-cycle pulse when the frame completes.
- `tx_data` out 1: serial line, registered, idle high.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Reset values: state IDLE, `tx_data`=1, `tx_busy`=0, `tx_done`=0, all counters 0.
- `tx_ready` = (state==IDLE), decoded combinationally, so it reads 1 while `rst` is held.
- Accept: `tx_valid && tx_ready` on a rising edge.
  - Latches `tx_data_in`, `parity_mode` and `stop_sel`.
  - Moves to START; tick counter cleared.
- Mid-frame input changes are ignored.
- `tx_valid` while busy is ignored; the word is not consumed.
- Each bit lasts exactly `OVERSAMPLE` ticks. The bit ends on the edge where the tick counter equals `OVERSAMPLE`-1 and `sample_tick`=1; the counter then clears. Ticks arriving in the accept cycle are not counted.
- START: drives 0.
- DATA: shift register, LSB first, `DATA_BITS` bits, using a bit counter of width clog2(`DATA_BITS`).
  - Exit to PARITY if parity is enabled, otherwise to STOP.
- PARITY: drives XOR of the latched word for even, or its complement for odd.
- STOP: drives 1 for `OVERSAMPLE`, 3·`OVERSAMPLE`/2 or 2·`OVERSAMPLE` ticks per `stop_sel`.
  - Tick counter width is clog2(2·`OVERSAMPLE`).
  - Then returns to IDLE.
- `tx_busy`=1 in every non-IDLE state.
- Reset mid-frame aborts the frame without a `tx_done` pulse; the line returns to 1.

## Timing
- `tx_data` is registered: the line takes the new state's level one clock after the state transition edge.
- The start bit appears on `tx_data` 1 clock after the accept edge.
- `tx_done` goes high in the cycle where state is back in IDLE, the same cycle `tx_ready` returns to 1.
- Back-to-back frames with `tx_valid` held high: the next word is accepted in the `tx_done` cycle.
  - Exactly 1 extra clock of idle-high separates the last stop bit from the next start bit.
- Frame length in ticks = `OVERSAMPLE`·(1 + `DATA_BITS` + P) + stop ticks, with P=1 when parity is enabled.
- If `rst` and `tx_valid` are both high, reset wins and nothing is accepted.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state and parity generator are present, and `parity_mode` behaves as above.
- `UART_TX_PARITY_EN` undefined: no PARITY state or logic is built.
  - `parity_mode` remains a port but is ignored.
  - Every frame is sent without parity.

## Test plan
All scenarios use `DATA_BITS`=8 and `OVERSAMPLE`=16, with `sample_tick` held at 1.
- 0x55, `parity_mode`=00, `stop_sel`=00 -> line reads 0,1,0,1,0,1,0,1,0,1 (start, data LSB first, stop), each bit 16 clocks; `tx_done` pulses 160 clocks after the start bit begins; `tx_busy` is high throughout.
- 0x07 with `parity_mode`=01 -> parity bit 1; same word with 10 -> parity bit 0; frame is 11 bits. With the macro undefined -> 10-bit frame and no parity bit.
- 0xFF, `stop_sel`=01 -> stop high for 24 clocks; `stop_sel`=10 -> 32 clocks before `tx_done`.
- 0xA5 then 0x3C with `tx_valid` held high -> second word accepted in the `tx_done` cycle; exactly one idle-high clock between frames; `tx_ready` is low during both frames.
- `rst` pulsed during data bit 3 of 0x81 -> next clock `tx_data`=1, `tx_busy`=0, no `tx_done`; a following 0x81 frame is bit-exact.
- `stop_sel` and `parity_mode` toggled mid-frame, and a new `tx_valid`/`tx_data_in` presented while busy -> current frame unchanged and the new word is not consumed.
